// File: rtl/cache_rd_arbiter_pkg.sv
// Shared definitions for the cache read arbiter: FSM state encoding,
// cache request type codes and the fixed AXI read-burst attributes.
package cache_rd_arbiter_pkg;

    // One transaction in flight: grant, address phase, data beats, return pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RET  = 2'd3
    } arb_state_t;

    // Request type codes driven by the caches.
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    // Every beat is 4 bytes wide; bursts are incrementing.
    localparam logic [2:0] AXI_ARSIZE  = 3'b010;
    localparam logic [1:0] AXI_ARBURST = 2'b01;

    // Burst length (beats minus one) for each request type.
    localparam logic [7:0] ARLEN_LINE = 8'd3;
    localparam logic [7:0] ARLEN_WORD = 8'd0;

    // Anything that is not an explicit line request is handled as a word.
    function automatic logic [2:0] norm_rd_type(input logic [2:0] t);
        return (t == RD_TYPE_LINE) ? RD_TYPE_LINE : RD_TYPE_WORD;
    endfunction

endpackage

// File: rtl/cache_rd_arbiter_grant.sv
// Two-requester grant logic for the cache read arbiter.
// Default: fixed priority, dcache (bit1) over icache (bit0).
// With ARB_RR_EN defined: round-robin using a one-bit last-owner register
// that hands priority to the requester that did not win last time.
module rd_grant (
`ifdef ARB_RR_EN
    input  logic       clk,
    input  logic       reset,
    input  logic       i_take,
`endif
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

`ifdef ARB_RR_EN
    // 0 = icache owned the last grant, 1 = dcache owned it.
    logic r_last_owner;

    // Remember who won each grant the arbiter actually accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_owner <= 1'b0;
        end else if (i_take && (|i_req)) begin
            r_last_owner <= o_gnt[1];
        end
    end

    // Priority goes to the requester that is not the last owner.
    always_comb begin
        o_gnt = 2'b00;
        if (!r_last_owner) begin
            if (i_req[1])      o_gnt = 2'b10;
            else if (i_req[0]) o_gnt = 2'b01;
        end else begin
            if (i_req[0])      o_gnt = 2'b01;
            else if (i_req[1]) o_gnt = 2'b10;
        end
    end
`else
    // Fixed priority: dcache first.
    always_comb begin
        o_gnt = 2'b00;
        if (i_req[1])      o_gnt = 2'b10;
        else if (i_req[0]) o_gnt = 2'b01;
    end
`endif

endmodule

// File: rtl/cache_rd_arbiter.sv
// Cache read arbiter: merges icache and dcache read requests onto a single
// AXI read channel, one transaction outstanding at a time, and returns a
// word or a 4-beat line to the owning requester.
// Optional feature macro: ARB_RR_EN (round-robin grant instead of
// dcache-first fixed priority).
// Handshakes: AR completes on arvalid && arready, R beats on rvalid && rready;
// rd_rdy is a one-cycle accept strobe that the cache samples with its rd_req.
module cache_rd_arbiter #(
    parameter int AXI_ID_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    // cache side
    input  logic [1:0]          rd_req,
    input  logic [5:0]          rd_type,
    input  logic [63:0]         rd_addr,
    output logic [1:0]          rd_rdy,
    output logic [1:0]          ret_valid,
    output logic [127:0]        ret_data,
    // AXI read address channel
    output logic [AXI_ID_W-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    // AXI read data channel
    input  logic [AXI_ID_W-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    // debug: current FSM state
    output logic [1:0]          o_dbg_state
);
    import cache_rd_arbiter_pkg::*;

    arb_state_t   r_state;
    arb_state_t   w_next_state;

    logic         r_owner;       // 0 = icache, 1 = dcache
    logic [2:0]   r_type;        // normalised request type
    logic [31:0]  r_addr;
    logic [1:0]   r_beat_cnt;
    logic [127:0] r_buf;         // beats assembled here, beat0 in [31:0]
    logic [127:0] r_ret_hold;    // last returned data, shown outside RET

    logic [1:0]   w_gnt;
    logic         w_idle;
    logic [2:0]   w_sel_type;
    logic [31:0]  w_sel_addr;
    logic         w_is_line;
    logic         w_unused_r;

    // The R channel ID and response are not used: only one read is ever
    // outstanding and errors are not reported back to the caches.
    assign w_unused_r = ^{rid, rresp};

    assign w_idle = (r_state == ST_IDLE);

    rd_grant u_grant (
`ifdef ARB_RR_EN
        .clk    (clk),
        .reset  (reset),
        .i_take (w_idle),
`endif
        .i_req  (rd_req),
        .o_gnt  (w_gnt)
    );

    // Fields of the winning requester.
    assign w_sel_type = w_gnt[1] ? rd_type[5:3]  : rd_type[2:0];
    assign w_sel_addr = w_gnt[1] ? rd_addr[63:32] : rd_addr[31:0];

    // AR channel fields come from the latched request and stay stable until
    // the handshake. Line reads are aligned to 16 bytes.
    assign w_is_line = (r_type == RD_TYPE_LINE);
    assign araddr    = w_is_line ? {r_addr[31:4], 4'b0000} : r_addr;
    assign arlen     = w_is_line ? ARLEN_LINE : ARLEN_WORD;
    assign arsize    = AXI_ARSIZE;
    assign arburst   = AXI_ARBURST;
    assign arid      = AXI_ID_W'(r_owner);

    // Inside RET the freshly assembled buffer is shown; otherwise the copy
    // taken during the last RET keeps ret_data steady.
    assign ret_data  = (r_state == ST_RET) ? r_buf : r_ret_hold;

    assign o_dbg_state = r_state;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs. Outputs are held low while reset is
    // asserted so that a half-finished transaction cannot complete a
    // handshake in the very cycle it is being abandoned.
    always_comb begin
        w_next_state = r_state;
        rd_rdy       = 2'b00;
        arvalid      = 1'b0;
        rready       = 1'b0;
        ret_valid    = 2'b00;
        case (r_state)
            ST_IDLE: begin
                rd_rdy = reset ? 2'b00 : w_gnt;
                if (|w_gnt) begin
                    w_next_state = ST_AR;
                end
            end
            ST_AR: begin
                arvalid = !reset;
                if (arready) begin
                    w_next_state = ST_R;
                end
            end
            ST_R: begin
                rready = !reset;
                if (rvalid && rlast) begin
                    w_next_state = ST_RET;
                end
            end
            ST_RET: begin
                if (!reset) begin
                    ret_valid = r_owner ? 2'b10 : 2'b01;
                end
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request latch, beat assembly and return-data hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= 1'b0;
            r_type     <= RD_TYPE_WORD;
            r_addr     <= 32'h0;
            r_beat_cnt <= 2'd0;
            r_buf      <= 128'h0;
            r_ret_hold <= 128'h0;
        end else begin
            if ((r_state == ST_IDLE) && (|w_gnt)) begin
                r_owner <= w_gnt[1];
                r_type  <= norm_rd_type(w_sel_type);
                r_addr  <= w_sel_addr;
            end
            if ((r_state == ST_AR) && arready) begin
                r_beat_cnt <= 2'd0;
            end
            if ((r_state == ST_R) && rvalid) begin
                r_buf[{r_beat_cnt, 5'b00000} +: 32] <= rdata;
                r_beat_cnt <= r_beat_cnt + 2'd1;
            end
            if (r_state == ST_RET) begin
                r_ret_hold <= r_buf;
            end
        end
    end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Self-checking bench for cache_rd_arbiter. Honours ARB_RR_EN when the
// bench and design are built with it defined.
module tb_cache_rd_arbiter;

    localparam int AXI_ID_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]          rd_req;
    logic [5:0]          rd_type;
    logic [63:0]         rd_addr;
    logic [1:0]          rd_rdy;
    logic [1:0]          ret_valid;
    logic [127:0]        ret_data;
    logic [AXI_ID_W-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [AXI_ID_W-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [1:0]          dbg_state;

    cache_rd_arbiter #(.AXI_ID_W(AXI_ID_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .rd_type     (rd_type),
        .rd_addr     (rd_addr),
        .rd_rdy      (rd_rdy),
        .ret_valid   (ret_valid),
        .ret_data    (ret_data),
        .arid        (arid),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .arvalid     (arvalid),
        .arready     (arready),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    logic [127:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic         m_last_owner;   // who won the previous grant (0 icache)
    logic [127:0] last_ret;       // data most recently returned
    logic [127:0] last_mask;      // bits of last_ret that are defined

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Who should win, from the arbitration rule alone.
    function automatic logic [1:0] model_grant(input logic [1:0] req);
        if (req != 2'b11) return req;
`ifdef ARB_RR_EN
        return m_last_owner ? 2'b01 : 2'b10;
`else
        return 2'b10;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete read transaction, starting at posedge+1 with the DUT idle.
    // reset_at >= 0 pulses reset just before that beat would be delivered.
    task automatic txn(input logic [1:0] req, input logic [2:0] t_i, input logic [2:0] t_d,
                       input logic [31:0] a_i, input logic [31:0] a_d,
                       input int ar_wait, input int max_gap, input int reset_at,
                       input bit use_fixed, input logic [127:0] fixed_line);
        logic [1:0]   win;
        logic         owner;
        logic [2:0]   t;
        logic [31:0]  a;
        logic [31:0]  exp_addr;
        logic         line;
        int           nbeats;
        int           gap;
        logic [127:0] beats;
        logic [127:0] mask;
        logic [127:0] exp_line;

        rd_req  = req;
        rd_type = {t_d, t_i};
        rd_addr = {a_d, a_i};
        #1;
        win = model_grant(req);
        chk("rd_rdy_grant", rd_rdy, win);
        chk("arvalid_idle", arvalid, 0);
        chk("rready_idle", rready, 0);

        owner    = win[1];
        t        = owner ? t_d : t_i;
        a        = owner ? a_d : a_i;
        line     = (t == 3'b100);
        exp_addr = line ? (a & 32'hFFFF_FFF0) : a;
        nbeats   = line ? 4 : 1;
        mask     = line ? {128{1'b1}} : 128'hFFFF_FFFF;
        m_last_owner = owner;
        for (int i = 0; i < 4; i++) begin
            beats[i*32 +: 32] = use_fixed ? fixed_line[i*32 +: 32] : $urandom;
        end
        exp_line = beats & mask;
        exp_q.push_back(exp_line);

        step();
        rd_req = req & ~win;
        chk("arvalid_T1", arvalid, 1);
        chk("araddr", araddr, exp_addr);
        chk("arlen", arlen, line ? 8'd3 : 8'd0);
        chk("arid", arid, {127'b0, owner});
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
        chk("rd_rdy_busy_ar", rd_rdy, 0);
        chk("ret_hold_ar", ret_data & last_mask, last_ret & last_mask);

        for (int w = 0; w < ar_wait; w++) begin
            arready = 1'b0;
            step();
            chk("arvalid_stable", arvalid, 1);
            chk("araddr_stable", araddr, exp_addr);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("arvalid_after_hs", arvalid, 0);
        chk("rready_r", rready, 1);

        for (int b = 0; b < nbeats; b++) begin
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                rvalid = 1'b0;
                step();
                chk("rready_gap", rready, 1);
            end
            if (b == reset_at) begin
                rd_req = 2'b00;
                rvalid = 1'b0;
                reset  = 1'b1;
                step();
                reset  = 1'b0;
                void'(exp_q.pop_back());
                m_last_owner = 1'b0;
                last_ret  = 128'h0;
                last_mask = {128{1'b1}};
                chk("rst_arvalid", arvalid, 0);
                chk("rst_rready", rready, 0);
                chk("rst_state_idle", dbg_state, 0);
                for (int k = 0; k < 3; k++) begin
                    chk("rst_no_ret", ret_valid, 0);
                    step();
                end
                return;
            end
            rvalid = 1'b1;
            rdata  = beats[b*32 +: 32];
            rlast  = (b == nbeats - 1);
            rid    = AXI_ID_W'($urandom);
            rresp  = 2'($urandom);
            chk("ret_not_early", ret_valid, 0);
            chk("rd_rdy_busy_r", rd_rdy, 0);
            step();
            rvalid = 1'b0;
            rlast  = 1'b0;
        end

        exp_line = exp_q.pop_front();
        chk("ret_valid_pulse", ret_valid, win);
        chk("ret_data", ret_data & mask, exp_line);
        chk("rd_rdy_busy_ret", rd_rdy, 0);
        last_ret  = exp_line;
        last_mask = mask;
        step();
        chk("ret_valid_one_cycle", ret_valid, 0);
        chk("ret_hold_idle", ret_data & last_mask, last_ret & last_mask);
        chk("state_idle", dbg_state, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] ti;
        logic [2:0] td;
        logic [1:0] rq;

        reset   = 1'b1;
        rd_req  = 2'b11;
        rd_type = 6'b100_100;
        rd_addr = 64'h0;
        arready = 1'b0;
        rid     = '0;
        rdata   = 32'h0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        m_last_owner = 1'b0;
        last_ret  = 128'h0;
        last_mask = {128{1'b1}};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_rdy", rd_rdy, 0);
        chk("reset_arvalid", arvalid, 0);
        chk("reset_rready", rready, 0);
        chk("reset_ret_valid", ret_valid, 0);
        chk("reset_ret_data", ret_data, 0);
        chk("reset_state", dbg_state, 0);
        reset  = 1'b0;
        rd_req = 2'b00;
        step();

        // icache line, immediate arready, known beats
        txn(2'b01, 3'b100, 3'b010, 32'h1FC0_0024, 32'h0, 0, 0, -1, 1'b1,
            {32'h44, 32'h33, 32'h22, 32'h11});
        // dcache word
        txn(2'b10, 3'b010, 3'b010, 32'h0, 32'hBFAF_8004, 0, 0, -1, 1'b0, 128'h0);
        // both requesting: first winner, then the other after RET
        txn(2'b11, 3'b100, 3'b010, 32'h0000_1230, 32'h8000_0008, 0, 0, -1, 1'b0, 128'h0);
        txn(2'b01, 3'b100, 3'b010, 32'h0000_1230, 32'h8000_0008, 0, 0, -1, 1'b0, 128'h0);
        // three contested rounds
        for (int r = 0; r < 3; r++) begin
            txn(2'b11, 3'b100, 3'b100, 32'h0000_2000 + 32'(r*16), 32'h9000_0000 + 32'(r*16),
                0, 0, -1, 1'b0, 128'h0);
        end
        // slow AR and gapped R beats
        txn(2'b01, 3'b100, 3'b010, 32'h1234_567C, 32'h0, 5, 3, -1, 1'b0, 128'h0);
        // reset after the second beat, then a normal request
        txn(2'b01, 3'b100, 3'b010, 32'h0000_4440, 32'h0, 1, 1, 2, 1'b0, 128'h0);
        txn(2'b10, 3'b010, 3'b100, 32'h0, 32'hA000_0044, 0, 1, -1, 1'b0, 128'h0);
        // undefined type codes behave as words
        txn(2'b01, 3'b111, 3'b010, 32'hCAFE_0006, 32'h0, 0, 0, -1, 1'b0, 128'h0);

        // randomized traffic
        for (int n = 0; n < 25; n++) begin
            rq = 2'($urandom_range(1, 3));
            ti = $urandom_range(0, 1) ? 3'b100 : 3'($urandom_range(0, 7));
            td = $urandom_range(0, 1) ? 3'b100 : 3'($urandom_range(0, 7));
            txn(rq, ti, td, $urandom, $urandom, $urandom_range(0, 3), 2, -1, 1'b0, 128'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
